// File: rtl/jump_ctrl.sv
// jump_ctrl: control-flow sequencer for the 5-bit-address core.
// The instruction word at PC_IN is captured into a one-stage decode register.
// Control opcodes drive JMP/JMP_ADDR to the program counter and squash the
// wrong-path slot. CALL/RET use a small return-address stack, and HALT parks
// the core until reset.
// Optional build macro JUMP_CTRL_JNZ_EN: when defined, opcode 010 becomes JNZ.
module jump_ctrl #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] PC_IN,
  input  logic [AW+2:0] INSTR,
  input  logic          ZERO,
  output logic          JMP,
  output logic [AW-1:0] JMP_ADDR,
  output logic          EXEC_VALID,
  output logic          HALTED,
  output logic          STK_ERR
);

  // The stack pointer must represent every value from 0 to DEPTH.
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  localparam logic [2:0] OpHalt = 3'b011;
  localparam logic [2:0] OpJmp  = 3'b100;
  localparam logic [2:0] OpJz   = 3'b101;
  localparam logic [2:0] OpCall = 3'b110;
  localparam logic [2:0] OpRet  = 3'b111;
`ifdef JUMP_CTRL_JNZ_EN
  localparam logic [2:0] OpJnz  = 3'b010;
`endif

  typedef enum logic {StRun, StHalted} state_e;

  state_e          r_state, w_state_d;
  logic [AW+2:0]   r_ir;
  logic [AW-1:0]   r_ir_pc;
  logic            r_ir_vld;
  logic [SPW-1:0]  r_sp;
  logic [AW-1:0]   r_stack [DEPTH];
  logic            r_stk_err;

  logic [2:0]      w_op;
  logic [AW-1:0]   w_tgt;
  logic [AW-1:0]   w_top;
  logic            w_jmp;
  logic [AW-1:0]   w_addr;
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;

  assign w_op  = r_ir[AW+2:AW];
  assign w_tgt = r_ir[AW-1:0];

  // Select the top-of-stack entry, which is the slot just below the stack pointer.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
    end
  end

  // Decode the live instruction into jump, stack and halt actions.
  always_comb begin
    w_jmp     = 1'b0;
    w_addr    = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_state_d = r_state;
    if (r_state == StHalted) begin
      // Keep the PC spinning on the HALT word.
      w_jmp  = 1'b1;
      w_addr = r_ir_pc;
    end else if (r_ir_vld) begin
      case (w_op)
        OpHalt: begin
          w_jmp     = 1'b1;
          w_addr    = r_ir_pc;
          w_state_d = StHalted;
        end
        OpJmp: begin
          w_jmp  = 1'b1;
          w_addr = w_tgt;
        end
        OpJz: begin
          w_jmp  = ZERO;
          w_addr = ZERO ? w_tgt : '0;
        end
        OpCall: begin
          // On overflow the jump is still taken, but the return address is dropped.
          w_jmp  = 1'b1;
          w_addr = w_tgt;
          if (r_sp == SPW'(DEPTH)) w_err_set = 1'b1;
          else                     w_push    = 1'b1;
        end
        OpRet: begin
          // On underflow RET behaves as a NOP.
          if (r_sp != '0) begin
            w_jmp  = 1'b1;
            w_addr = w_top;
            w_pop  = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
`ifdef JUMP_CTRL_JNZ_EN
        OpJnz: begin
          w_jmp  = ~ZERO;
          w_addr = ZERO ? '0 : w_tgt;
        end
`endif
        default: ;
      endcase
    end
  end

  assign JMP        = w_jmp;
  assign JMP_ADDR   = w_addr;
  assign EXEC_VALID = r_ir_vld & (r_state == StRun);
  assign HALTED     = (r_state == StHalted);
  assign STK_ERR    = r_stk_err;

  // Update the state, decode register, stack pointer and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StRun;
      r_ir      <= '0;
      r_ir_pc   <= '0;
      r_ir_vld  <= 1'b0;
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_state <= w_state_d;
      // Freeze the decode register on entry to HALTED so IR_PC keeps the halt address.
      if (w_state_d == StRun) begin
        r_ir     <= INSTR;
        r_ir_pc  <= PC_IN;
        r_ir_vld <= ~w_jmp;
      end
      if (w_push)     r_sp <= r_sp + SPW'(1);
      else if (w_pop) r_sp <= r_sp - SPW'(1);
      if (w_err_set) r_stk_err <= 1'b1;
    end
  end

  // Write the return address. Stack contents are not reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!RST && w_push && (r_sp == SPW'(i))) r_stack[i] <= r_ir_pc + AW'(1);
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: randomized and directed program runs for jump_ctrl.
// The bench models the program counter and ROM itself. A behavioural model
// built on a queue-based return stack predicts every output on every cycle.
module tb_jump_ctrl;

  logic       CLK;
  logic       RST;
  logic [4:0] PC_IN;
  logic [7:0] INSTR;
  logic       ZERO;
  logic       JMP;
  logic [4:0] JMP_ADDR;
  logic       EXEC_VALID;
  logic       HALTED;
  logic       STK_ERR;

  jump_ctrl #(.AW(5), .DEPTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PC_IN     (PC_IN),
    .INSTR     (INSTR),
    .ZERO      (ZERO),
    .JMP       (JMP),
    .JMP_ADDR  (JMP_ADDR),
    .EXEC_VALID(EXEC_VALID),
    .HALTED    (HALTED),
    .STK_ERR   (STK_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Program ROM and reference model state.
  logic [7:0] rom [32];
  logic [4:0] m_pc;
  logic [7:0] m_ir;
  logic [4:0] m_ir_pc;
  logic       m_vld;
  logic       m_halt;
  logic       m_err;
  logic       m_known = 1'b0;
  logic [4:0] m_stk [$];
  int         zmode;   // 0: ZERO held at 0, 1: ZERO held at 1, 2: random

  // Compute the jump the model expects from its current state and the ZERO flag.
  task automatic model_eval(input logic z, output logic jmp, output logic [4:0] addr);
    jmp  = 1'b0;
    addr = 5'd0;
    if (m_halt) begin
      jmp  = 1'b1;
      addr = m_ir_pc;
    end else if (m_vld) begin
      case (m_ir[7:5])
        3'd3: begin jmp = 1'b1; addr = m_ir_pc; end
        3'd4: begin jmp = 1'b1; addr = m_ir[4:0]; end
        3'd5: if (z) begin jmp = 1'b1; addr = m_ir[4:0]; end
        3'd6: begin jmp = 1'b1; addr = m_ir[4:0]; end
        3'd7: if (m_stk.size() > 0) begin jmp = 1'b1; addr = m_stk[$]; end
`ifdef JUMP_CTRL_JNZ_EN
        3'd2: if (!z) begin jmp = 1'b1; addr = m_ir[4:0]; end
`endif
        default: ;
      endcase
    end
  endtask

  // Run one clock cycle: drive the inputs, compare the outputs, then advance the model.
  task automatic step(input logic rst);
    logic       z;
    logic       e_jmp;
    logic [4:0] e_addr;
    @(negedge CLK);
    z     = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    RST   = rst;
    ZERO  = z;
    PC_IN = m_pc;
    INSTR = rom[m_pc];
    #1;
    model_eval(z, e_jmp, e_addr);
    if (m_known) begin
      check_eq("jmp",        32'(JMP),        32'(e_jmp));
      check_eq("jmp_addr",   32'(JMP_ADDR),   32'(e_addr));
      check_eq("exec_valid", 32'(EXEC_VALID), 32'(m_vld & ~m_halt));
      check_eq("halted",     32'(HALTED),     32'(m_halt));
      check_eq("stk_err",    32'(STK_ERR),    32'(m_err));
    end
    @(posedge CLK);
    if (rst) begin
      m_known = 1'b1;
      m_pc    = 5'd0;
      m_ir    = 8'd0;
      m_ir_pc = 5'd0;
      m_vld   = 1'b0;
      m_halt  = 1'b0;
      m_err   = 1'b0;
      m_stk.delete();
    end else begin
      if (!m_halt) begin
        if (m_vld) begin
          if (m_ir[7:5] == 3'd6) begin
            if (m_stk.size() < 4) m_stk.push_back(m_ir_pc + 5'd1);
            else                  m_err = 1'b1;
          end else if (m_ir[7:5] == 3'd7) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else                  m_err = 1'b1;
          end else if (m_ir[7:5] == 3'd3) begin
            m_halt = 1'b1;
          end
        end
        if (!m_halt) begin
          m_ir    = rom[m_pc];
          m_ir_pc = m_pc;
          m_vld   = ~e_jmp;
        end
      end
      // The bench's program counter follows the predicted jump, so a DUT
      // divergence cannot steer the stimulus.
      m_pc = e_jmp ? e_addr : m_pc + 5'd1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b1);
  endtask

  // Fill the ROM with plain ALU/NOP words (opcodes 000 and 001).
  task automatic fill_nops();
    for (int i = 0; i < 32; i++) rom[i] = {3'($urandom_range(0, 1)), 5'($urandom)};
  endtask

  initial begin
    RST   = 1'b1;
    ZERO  = 1'b0;
    PC_IN = '0;
    INSTR = '0;
    zmode = 2;

    // NOP-only program.
    fill_nops();
    do_reset();
    run(40);

    // JMP 0x10 at address 3.
    fill_nops();
    rom[3] = {3'd4, 5'h10};
    do_reset();
    run(30);

    // JZ 0x08 at address 2: first not taken, then taken.
    fill_nops();
    rom[2] = {3'd5, 5'h08};
    zmode  = 0;
    do_reset();
    run(12);
    zmode  = 1;
    do_reset();
    run(12);
    zmode  = 2;

    // CALL/RET, including a CALL at address 31 whose return address wraps to 0.
    fill_nops();
    rom[5]  = {3'd6, 5'h14};
    rom[20] = {3'd7, 5'h00};
    rom[10] = {3'd4, 5'h1F};
    rom[31] = {3'd6, 5'h18};
    rom[24] = {3'd7, 5'h00};
    do_reset();
    run(80);

    // Five nested CALLs overflow the four-entry stack, then the program halts.
    fill_nops();
    for (int i = 0; i < 5; i++) rom[i] = {3'd6, 5'(i + 1)};
    rom[8] = {3'd3, 5'h00};
    do_reset();
    run(25);

    // RET on an empty stack, HALT at 0x0C held for a while, then reset mid-halt.
    fill_nops();
    rom[1]  = {3'd7, 5'h00};
    rom[12] = {3'd3, 5'h00};
    do_reset();
    run(30);
    do_reset();
    run(3);

    // Opcode 010 with target 0x1F and ZERO=0: JNZ when the macro is enabled, NOP otherwise.
    fill_nops();
    rom[2] = {3'd2, 5'h1F};
    zmode  = 0;
    do_reset();
    run(10);
    zmode  = 2;

    // Random programs with occasional mid-run resets.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 60; c++) step($urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
